i3c_host_master: RTL and testbench
==================================

// Module: i3c_host_master
// PURPOSE
//  Initiator end of the 3-wire I3C link (bus_clk / bus_dout / bus_din) used by the camera board's command responder.
//  Accepts one 16-bit command word from a local host port, generates bus_clk and shifts the word out MSB-first.
//  Captures the 16-bit reply shifted back in the same frame.
//  Inserts a fixed inter-frame gap after each frame so the responder can decode, act and re-arm its receiver.
//  Used by on-board test masters and the bridge from the PC link.
// PARAMETERS
//  CLK_DIV     8   bus_clk half-period in clk_fast cycles; legal range 1..255
//  GAP_CYCLES  64  idle clk_fast cycles after each frame, with bus_clk low; legal range 1..65535
// PORTS
//  clk_fast    in   1   single clock; all logic on posedge
//  nrst        in   1   synchronous reset, active low
//  cmd_valid   in   1   command word offered
//  cmd_ready   out  1   engine idle; command accepted when cmd_valid&&cmd_ready
//  cmd_word    in   16  {data[15:8], group[7:4], subcode[3:0]}
//  resp_valid  out  1   one-cycle pulse: resp_word holds the reply of the frame just finished
//  resp_word   out  16  reply captured from bus_din, MSB first; holds until the next frame ends
//  busy        out  1   high from acceptance until the gap has expired
//  bus_clk     out  1   link clock; idles low
//  bus_dout    out  1   serial command data toward the responder
//  bus_din     in   1   serial reply data from the responder
//  dbg_state   out  2   current FSM state encoding
// BEHAVIOUR
//  Reset (nrst=0 at posedge): state IDLE.
//   - bus_clk=0, bus_dout=0, cmd_ready=0, busy=0.
//   - resp_valid=0, resp_word=0, dbg_state=0.
//   - All counters cleared.
//   - cmd_ready rises on the first posedge with nrst=1.
//  FSM: IDLE(0) -> SHIFT(1) -> GAP(2) -> IDLE. Encoding 3 is illegal and goes to IDLE on the next edge.
//  IDLE:
//   - cmd_ready=1.
//   - On accept: latch cmd_word into the TX shift register, drive bus_dout=cmd_word[15] on the next edge, set busy=1, go to SHIFT.
//   - cmd_word is sampled only on the accept cycle.
//  SHIFT: 16 bit periods, each 2*CLK_DIV cycles.
//   - Low half: bus_clk=0 for CLK_DIV cycles, bus_dout stable.
//   - High half: bus_clk=1 for CLK_DIV cycles.
//   - The responder samples bus_dout on the bus_clk rise.
//   - The master samples bus_din on the clk_fast edge where bus_clk goes 0->1, shifting it into resp_sr[0].
//   - On the bus_clk fall ending bit k (k<15), bus_dout advances to the next lower bit.
//   - Frame length is exactly 32*CLK_DIV clk_fast cycles from the first low half to the last fall.
//   - After the 16th fall: bus_clk=0, bus_dout=0, resp_word<=resp_sr, resp_valid=1 for one cycle, go to GAP.
//  GAP:
//   - Count GAP_CYCLES cycles with bus_clk=0, then IDLE.
//   - busy drops and cmd_ready rises in the same cycle.
//   - Minimum command-to-command spacing is 1 + 32*CLK_DIV + GAP_CYCLES cycles.
//   - cmd_valid during SHIFT or GAP is ignored, not queued.
//  Protocol latency: the reply in frame N is what the responder prepared while decoding frame N-1.
//   - Burst-read loop0 replies are stale data and must be treated as dummies.
//   - Data for index i arrives in the frame after the one that requested it.
//  Reset mid-frame:
//   - On the next posedge: bus_clk=0, bus_dout=0, no resp_valid, resp_word=0.
//   - The partial frame is abandoned; the responder's receiver must be re-armed by its own reset.
//  Counters: divider width 8 bits, bit counter 4 bits, gap counter 16 bits. None may wrap inside a state.
// TESTING
//  T1 reset: nrst low 3 cycles, mid-stream -> all outputs 0; cmd_ready=1 one cycle after nrst=1.
//  T2 single frame, CLK_DIV=2:
//   - Stimulus: cmd_word=16'h0041; bus_din model returns 16'hABCD MSB-first.
//   - 16 bus_clk pulses, 64-cycle frame.
//   - bus_dout at each rise = 0000_0000_0100_0001.
//   - resp_valid one pulse; resp_word=16'hABCD.
//  T3 back-to-back: cmd_valid held with 16'h0042 then 16'h0051.
//   - Second word accepted exactly 1+32*CLK_DIV+GAP_CYCLES cycles after the first.
//   - cmd_ready=0 throughout SHIFT/GAP.
//  T4 reset while bit 7 is high:
//   - Next edge: bus_clk=0, bus_dout=0, no resp_valid.
//   - A fresh 16'h0012 frame then completes normally.
//  T5 burst read against a behavioural responder: send 0x0051, 0x0052, 0x0053, 0x0054.
//   - Reply of 0x0053 equals buffer[0].
//   - Reply of 0x0052 is the dummy.
//  T6 CLK_DIV=1, GAP_CYCLES=1:
//   - 32-cycle frame, bus_clk toggles every cycle.
//   - Correct resp_word=16'h5AA5.
//   - Next accept 34 cycles after the previous accept.

Source files
------------

// File: rtl/i3c_host_master.sv
`default_nettype none
// ============================================================================
// i3c_host_master: 3-wire link initiator, 16-bit command out / 16-bit reply in
// Rev 1.0
// ============================================================================
module i3c_host_master #(
    parameter int CLK_DIV    = 8,
    parameter int GAP_CYCLES = 64
) (
    input  logic        clk_fast,
    input  logic        nrst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [15:0] cmd_word,
    output logic        resp_valid,
    output logic [15:0] resp_word,
    output logic        busy,
    output logic        bus_clk,
    output logic        bus_dout,
    input  logic        bus_din,
    output logic [1:0]  dbg_state
);

    localparam logic [7:0]  c_div_last = 8'(CLK_DIV - 1);
    localparam logic [15:0] c_gap_last = 16'(GAP_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SHIFT   = 2'd1,
        GAP     = 2'd2,
        ILLEGAL = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  div_q, div_d;
    logic [3:0]  bit_q, bit_d;
    logic [15:0] gap_q, gap_d;
    logic [14:0] tx_q, tx_d;
    logic [15:0] rx_q, rx_d;
    logic        clk_q, clk_d;
    logic        dout_q, dout_d;
    logic [15:0] resp_word_q, resp_word_d;
    logic        resp_valid_q, resp_valid_d;
    logic        ready_q, ready_d;
    logic        busy_q, busy_d;

    always_ff @(posedge clk_fast) begin
        if (!nrst) begin
            state_q      <= IDLE;
            div_q        <= '0;
            bit_q        <= '0;
            gap_q        <= '0;
            tx_q         <= '0;
            rx_q         <= '0;
            clk_q        <= 1'b0;
            dout_q       <= 1'b0;
            resp_word_q  <= '0;
            resp_valid_q <= 1'b0;
            ready_q      <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            div_q        <= div_d;
            bit_q        <= bit_d;
            gap_q        <= gap_d;
            tx_q         <= tx_d;
            rx_q         <= rx_d;
            clk_q        <= clk_d;
            dout_q       <= dout_d;
            resp_word_q  <= resp_word_d;
            resp_valid_q <= resp_valid_d;
            ready_q      <= ready_d;
            busy_q       <= busy_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        div_d        = div_q;
        bit_d        = bit_q;
        gap_d        = gap_q;
        tx_d         = tx_q;
        rx_d         = rx_q;
        clk_d        = clk_q;
        dout_d       = dout_q;
        resp_word_d  = resp_word_q;
        resp_valid_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (cmd_valid && ready_q) begin
                    state_d = SHIFT;
                    tx_d    = cmd_word[14:0];
                    dout_d  = cmd_word[15];
                    div_d   = '0;
                    bit_d   = '0;
                    clk_d   = 1'b0;
                end
            end
            SHIFT: begin
                if (div_q == c_div_last) begin
                    div_d = '0;
                    if (!clk_q) begin
                        // Rising edge: the reply bit is captured on the same edge bus_clk goes high
                        clk_d = 1'b1;
                        rx_d  = {rx_q[14:0], bus_din};
                    end else begin
                        clk_d = 1'b0;
                        if (bit_q == 4'd15) begin
                            dout_d       = 1'b0;
                            resp_word_d  = rx_q;
                            resp_valid_d = 1'b1;
                            gap_d        = '0;
                            state_d      = GAP;
                        end else begin
                            bit_d  = bit_q + 4'd1;
                            dout_d = tx_q[14];
                            tx_d   = {tx_q[13:0], 1'b0};
                        end
                    end
                end else begin
                    div_d = div_q + 8'd1;
                end
            end
            GAP: begin
                if (gap_q == c_gap_last) begin
                    state_d = IDLE;
                end else begin
                    gap_d = gap_q + 16'd1;
                end
            end
            default: begin
                state_d = IDLE;
                clk_d   = 1'b0;
                dout_d  = 1'b0;
            end
        endcase

        // Handshake flags are registered from the next state so ready and busy flip together
        ready_d = (state_d == IDLE);
        busy_d  = (state_d != IDLE);
    end

    assign cmd_ready  = ready_q;
    assign busy       = busy_q;
    assign bus_clk    = clk_q;
    assign bus_dout   = dout_q;
    assign resp_valid = resp_valid_q;
    assign resp_word  = resp_word_q;
    assign dbg_state  = state_q;

endmodule
`default_nettype wire

// File: tb/tb_i3c_host_master.sv
`default_nettype none
// ============================================================================
// tb_i3c_host_master: directed + randomized frames against a behavioural responder
// Rev 1.0
// ============================================================================
module tb_i3c_host_master;

    localparam int          c_div_a   = 2;
    localparam int          c_gap_a   = 20;
    localparam int          c_div_b   = 1;
    localparam int          c_gap_b   = 1;
    localparam int          c_timeout = 4000;
    localparam logic [15:0] c_dummy   = 16'hD0D0;

    logic        clk_fast = 1'b0;
    logic        nrst;
    logic        cmd_valid;
    logic [15:0] cmd_word;
    logic        bus_din;
    logic        sel;

    logic        a_ready, a_rvalid, a_busy, a_bclk, a_bdout;
    logic [15:0] a_rword;
    logic [1:0]  a_state;
    logic        b_ready, b_rvalid, b_busy, b_bclk, b_bdout;
    logic [15:0] b_rword;
    logic [1:0]  b_state;

    logic        w_ready, w_rvalid, w_busy, w_bclk, w_bdout;
    logic [15:0] w_rword;
    logic [1:0]  w_state;

    int          n_checks = 0;
    int          n_errors = 0;
    int          cyc = 0;
    int          div_cur, gap_cur;
    int          acc_edge, last_acc;
    logic [15:0] last_resp;
    logic [15:0] buffer [8];
    int          burst_idx;
    logic [15:0] prepared;

    always #5 clk_fast = ~clk_fast;
    always @(posedge clk_fast) cyc <= cyc + 1;

    i3c_host_master #(.CLK_DIV(c_div_a), .GAP_CYCLES(c_gap_a)) u_dut_a (
        .clk_fast(clk_fast), .nrst(nrst), .cmd_valid(cmd_valid), .cmd_ready(a_ready),
        .cmd_word(cmd_word), .resp_valid(a_rvalid), .resp_word(a_rword), .busy(a_busy),
        .bus_clk(a_bclk), .bus_dout(a_bdout), .bus_din(bus_din), .dbg_state(a_state)
    );

    i3c_host_master #(.CLK_DIV(c_div_b), .GAP_CYCLES(c_gap_b)) u_dut_b (
        .clk_fast(clk_fast), .nrst(nrst), .cmd_valid(cmd_valid), .cmd_ready(b_ready),
        .cmd_word(cmd_word), .resp_valid(b_rvalid), .resp_word(b_rword), .busy(b_busy),
        .bus_clk(b_bclk), .bus_dout(b_bdout), .bus_din(bus_din), .dbg_state(b_state)
    );

    assign w_ready  = sel ? b_ready  : a_ready;
    assign w_rvalid = sel ? b_rvalid : a_rvalid;
    assign w_busy   = sel ? b_busy   : a_busy;
    assign w_bclk   = sel ? b_bclk   : a_bclk;
    assign w_bdout  = sel ? b_bdout  : a_bdout;
    assign w_rword  = sel ? b_rword  : a_rword;
    assign w_state  = sel ? b_state  : a_state;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Responder: decodes a finished command and prepares the reply for the following frame
    task automatic responder_decode(input logic [15:0] c);
        if (c[7:4] == 4'h5 && c[3:0] == 4'h1) begin
            burst_idx = 0;
            prepared  = c_dummy;
        end else if (c[7:4] == 4'h5) begin
            prepared  = buffer[burst_idx % 8];
            burst_idx = burst_idx + 1;
        end else begin
            prepared  = {c[3:0], c[7:4], c[15:8]} ^ 16'h5A5A;
        end
    endtask

    task automatic do_reset(input int n, input string tag);
        nrst      = 1'b0;
        cmd_valid = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk_fast);
            check_eq({tag, "/rst_outs"},
                     {w_bclk, w_bdout, w_rvalid, w_rword, w_busy, w_ready, w_state}, 32'h0);
        end
        nrst = 1'b1;
        check_eq({tag, "/ready_before_release_edge"}, w_ready, 1'b0);
        @(negedge clk_fast);
        check_eq({tag, "/ready_after_release"}, {w_ready, w_busy, w_state}, {1'b1, 1'b0, 2'd0});
        prepared  = 16'h0000;
        burst_idx = 0;
    endtask

    task automatic run_frame(input logic [15:0] cmd, input logic [15:0] reply, input bit hold,
                             input bit chk_space, input int abort_rise, input string tag);
        int          t, rises, fall_edge, ready_bad, gap_clk_bad;
        logic        prev_clk, done;
        logic [15:0] got_cmd, got_resp;
        cmd_word  = cmd;
        cmd_valid = 1'b1;
        bus_din   = reply[15];
        t = 0;
        while (!w_ready && t < c_timeout) begin
            @(negedge clk_fast);
            t++;
        end
        check_eq({tag, "/accept_in_time"}, (t < c_timeout), 1'b1);
        acc_edge = cyc + 1;
        if (chk_space) check_eq({tag, "/accept_spacing"}, acc_edge - last_acc, 1 + 32 * div_cur + gap_cur);
        last_acc = acc_edge;
        @(negedge clk_fast);
        if (!hold) cmd_valid = 1'b0;
        check_eq({tag, "/accepted"}, {w_busy, w_ready, w_state, w_bclk, w_bdout},
                 {1'b1, 1'b0, 2'd1, 1'b0, cmd[15]});

        rises = 0; fall_edge = -1; ready_bad = 0; gap_clk_bad = 0;
        prev_clk = 1'b0; done = 1'b0; got_cmd = '0; got_resp = '0; t = 0;
        while (!done && t < c_timeout) begin
            @(negedge clk_fast);
            t++;
            if (w_ready) ready_bad++;
            if (w_bclk && !prev_clk) begin
                got_cmd = {got_cmd[14:0], w_bdout};
                rises++;
                if (rises < 16) bus_din = reply[15 - rises];
                if (abort_rise != 0 && rises == abort_rise) begin
                    do_reset(3, {tag, "/abort"});
                    return;
                end
            end
            if (!w_bclk && prev_clk) fall_edge = cyc;
            if (w_rvalid) begin
                got_resp = w_rword;
                done     = 1'b1;
            end
            prev_clk = w_bclk;
        end
        last_resp = got_resp;
        check_eq({tag, "/resp_seen"}, done, 1'b1);
        check_eq({tag, "/rises"}, rises, 16);
        check_eq({tag, "/dout_bits"}, got_cmd, cmd);
        check_eq({tag, "/resp_word"}, got_resp, reply);
        check_eq({tag, "/frame_len"}, fall_edge - acc_edge, 32 * div_cur);
        check_eq({tag, "/frame_end"}, {w_state, w_busy, w_bclk, w_bdout}, {2'd2, 1'b1, 1'b0, 1'b0});
        check_eq({tag, "/ready_in_shift"}, ready_bad, 0);

        @(negedge clk_fast);
        check_eq({tag, "/resp_pulse"}, {w_rvalid, w_rword}, {1'b0, reply});
        t = 0;
        while (!w_ready && t < c_timeout) begin
            if (w_bclk || w_bdout) gap_clk_bad++;
            @(negedge clk_fast);
            t++;
        end
        check_eq({tag, "/gap_len"}, cyc - fall_edge, gap_cur);
        check_eq({tag, "/gap_end"}, {w_busy, w_state, w_rword}, {1'b0, 2'd0, reply});
        check_eq({tag, "/gap_bus_quiet"}, gap_clk_bad, 0);
    endtask

    task automatic model_frame(input logic [15:0] cmd, input string tag);
        logic [15:0] reply;
        reply = prepared;
        run_frame(cmd, reply, 1'b0, 1'b0, 0, tag);
        responder_decode(cmd);
    endtask

    initial begin
        nrst      = 1'b0;
        cmd_valid = 1'b0;
        cmd_word  = '0;
        bus_din   = 1'b0;
        sel       = 1'b0;
        last_acc  = 0;
        last_resp = '0;
        prepared  = '0;
        burst_idx = 0;
        for (int i = 0; i < 8; i++) buffer[i] = 16'($urandom);

        div_cur = c_div_a;
        gap_cur = c_gap_a;
        do_reset(3, "T1_powerup");

        run_frame(16'h0041, 16'hABCD, 1'b0, 1'b0, 0, "T2");

        run_frame(16'h0042, 16'($urandom), 1'b1, 1'b0, 0, "T3a");
        run_frame(16'h0051, 16'($urandom), 1'b0, 1'b1, 0, "T3b");

        run_frame(16'h1234, 16'($urandom), 1'b0, 1'b0, 3, "T1_midframe");
        run_frame(16'h00F7, 16'($urandom), 1'b0, 1'b0, 8, "T4_abort");
        run_frame(16'h0012, 16'h3C3C, 1'b0, 1'b0, 0, "T4_fresh");

        prepared  = '0;
        burst_idx = 0;
        model_frame(16'h0051, "T5_51");
        model_frame(16'h0052, "T5_52");
        check_eq("T5_dummy", last_resp, c_dummy);
        model_frame(16'h0053, "T5_53");
        check_eq("T5_buf0", last_resp, buffer[0]);
        model_frame(16'h0054, "T5_54");
        check_eq("T5_buf1", last_resp, buffer[1]);

        for (int i = 0; i < 4; i++) begin
            model_frame({8'($urandom), ($urandom_range(0, 1) == 1) ? 4'h5 : 4'($urandom),
                         4'($urandom_range(1, 3))}, "R_model");
        end
        for (int i = 0; i < 4; i++) begin
            run_frame(16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)), 1'b0, 0, "R_free");
        end

        sel     = 1'b1;
        div_cur = c_div_b;
        gap_cur = c_gap_b;
        do_reset(3, "T6_reset");
        run_frame(16'hC3A1, 16'h5AA5, 1'b1, 1'b0, 0, "T6a");
        run_frame(16'h7E18, 16'h5AA5, 1'b1, 1'b1, 0, "T6b");
        run_frame(16'($urandom), 16'($urandom), 1'b0, 1'b1, 0, "T6c");
        for (int i = 0; i < 4; i++) begin
            run_frame(16'($urandom), 16'($urandom), 1'b0, 1'b0, 0, "R_fast");
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", n_checks, n_errors);
        $fatal(1);
    end

endmodule
`default_nettype wire
